// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: envelope state encodings and wave constants.
package synth_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    localparam int         WAV_W   = 8;
    localparam logic [7:0] WAV_MID = 8'd128;

endpackage

// File: rtl/synth_env_tick.sv
// Envelope/LFO timebase: counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick.
module synth_env_tick #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Tick is a decode of the counter, so it lands in the same cycle the counter wraps.
    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/synth_envelope.sv
// ADSR amplitude envelope: gate-driven level scales the wave about mid-scale.
// Optional PWM DAC output when SYNTH_ENV_PWM_EN is defined.
module synth_envelope
    import synth_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int ACC_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       gate,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] sustain_lvl,
    input  logic [7:0] release_rate,
    input  logic [7:0] wav_in,
    output logic [7:0] wav_out,
    output logic [7:0] env_level,
    output logic       busy
`ifdef SYNTH_ENV_PWM_EN
    ,
    output logic       pwm_out
`endif
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    env_state_t         state;
    logic [ACC_W-1:0]   acc;
    logic               gate_q;
    logic               tick;
    logic               rise;
    logic               fall;
    logic [7:0]         rate;
    logic [ACC_W:0]     step;
    logic [ACC_W:0]     sum;
    logic [ACC_W:0]     target;
    logic signed [8:0]  wav_s;
    logic signed [17:0] prod;

    synth_env_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate;
        end
    end

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    always_comb begin
        rate = 8'd0;
        case (state)
            ENV_ATTACK:  rate = attack_rate;
            ENV_DECAY:   rate = decay_rate;
            ENV_RELEASE: rate = release_rate;
            default:     rate = 8'd0;
        endcase
    end

    assign step   = (ACC_W+1)'(rate) + (ACC_W+1)'(1);
    assign sum    = {1'b0, acc} + step;
    assign target = {1'b0, sustain_lvl, {(ACC_W-8){1'b0}}};

    // Gate edges take priority over the tick; comparisons are rearranged to avoid signed underflow.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state <= ENV_IDLE;
            acc   <= '0;
        end else begin
            case (state)
                ENV_IDLE: begin
                    acc <= '0;
                    if (rise) begin
                        state <= ENV_ATTACK;
                    end
                end
                ENV_ATTACK: begin
                    if (fall) begin
                        state <= ENV_RELEASE;
                    end else if (tick) begin
                        if (sum >= {1'b0, ACC_MAX}) begin
                            acc   <= ACC_MAX;
                            state <= ENV_DECAY;
                        end else begin
                            acc <= sum[ACC_W-1:0];
                        end
                    end
                end
                ENV_DECAY: begin
                    if (fall) begin
                        state <= ENV_RELEASE;
                    end else if (rise) begin
                        state <= ENV_ATTACK;
                    end else if (tick) begin
                        if ({1'b0, acc} <= target + step) begin
                            acc   <= target[ACC_W-1:0];
                            state <= ENV_SUSTAIN;
                        end else begin
                            acc <= acc - step[ACC_W-1:0];
                        end
                    end
                end
                ENV_SUSTAIN: begin
                    if (fall) begin
                        state <= ENV_RELEASE;
                    end else if (tick) begin
                        acc <= target[ACC_W-1:0];
                    end
                end
                ENV_RELEASE: begin
                    if (rise) begin
                        state <= ENV_ATTACK;
                    end else if (tick) begin
                        if ({1'b0, acc} <= step) begin
                            acc   <= '0;
                            state <= ENV_IDLE;
                        end else begin
                            acc <= acc - step[ACC_W-1:0];
                        end
                    end
                end
                default: begin
                    state <= ENV_IDLE;
                    acc   <= '0;
                end
            endcase
        end
    end

    assign env_level = acc[ACC_W-1 -: 8];
    assign busy      = (state != ENV_IDLE);

    // Gain is env_level/256, so full level yields 255/256 and the output never reaches 255.
    assign wav_s = $signed({1'b0, wav_in}) - 9'sd128;
    assign prod  = wav_s * $signed({1'b0, env_level});

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            wav_out <= WAV_MID;
        end else begin
            wav_out <= WAV_MID + prod[15:8];
        end
    end

`ifdef SYNTH_ENV_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 8'd0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            pwm_out <= (pwm_cnt < wav_out);
        end
    end
`endif

endmodule
